// File: rtl/seg_disp_ctrl.sv
// Binary-to-BCD sequencing controller driving a bank of bcd7seg decoders.
// Latency: WIDTH cycles from in_valid&in_ready to updated bcd/dig_en (done pulses then).
// Backpressure: in_ready low during conversion; no queuing, source holds in_data until accepted.
//
// Ports:
//   clk, rst_n        clock, async active-low reset (sync release expected upstream)
//   in_valid/in_ready valid/ready handshake for in_data (unsigned binary value)
//   blank             level, forces dig_en low combinationally
//   done              one-cycle pulse when bcd/dig_en have just been updated
//   bcd               digit nibbles, digit i at [4i+3:4i]
//   dig_en            per-digit enable with leading-zero blanking
module seg_disp_ctrl #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  input  logic                  blank,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     dig_en
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CONV = 1'b1;

  logic [0:0]          state;
  logic [WIDTH-1:0]    sh;
  logic [4*DIGITS-1:0] acc;
  logic [CW-1:0]       cnt;
  logic [4*DIGITS-1:0] bcd_reg;
  logic [DIGITS-1:0]   en_reg;
  logic                done_reg;

  logic [4*DIGITS-1:0] acc_adj;
  logic [4*DIGITS-1:0] acc_next;
  logic [WIDTH-1:0]    sh_next;
  logic [DIGITS-1:0]   en_next;
  logic                any_upper;

  // Add-3 correction per nibble, no inter-nibble carry; applied before the shift.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  assign acc_next = {acc_adj[4*DIGITS-2:0], sh[WIDTH-1]};
  assign sh_next  = {sh[WIDTH-2:0], 1'b0};

  // Leading-zero blanking: digit i lit iff any digit at or above i is nonzero.
  // Digit 0 is always lit so a zero value still shows "0".
  always_comb begin
    en_next    = '0;
    any_upper  = 1'b0;
    en_next[0] = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      any_upper  = any_upper | (|acc_next[4*i +: 4]);
      en_next[i] = any_upper;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sh       <= '0;
      acc      <= '0;
      cnt      <= '0;
      bcd_reg  <= '0;
      en_reg   <= DIGITS'(1);
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh    <= in_data;
            acc   <= '0;
            cnt   <= CW'(WIDTH);
            state <= CONV;
          end
        end
        default: begin
          acc <= acc_next;
          sh  <= sh_next;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bcd_reg  <= acc_next;
            en_reg   <= en_next;
            done_reg <= 1'b1;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign done     = done_reg;
  assign bcd      = bcd_reg;
  assign dig_en   = en_reg & {DIGITS{~blank}};

endmodule

// File: tb/tb_seg_disp_ctrl.sv
module tb_seg_disp_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        blank;
  logic        done;
  logic [19:0] bcd;
  logic [4:0]  dig_en;

  int checks = 0;
  int errors = 0;

  seg_disp_ctrl #(.WIDTH(16), .DIGITS(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .blank    (blank),
    .done     (done),
    .bcd      (bcd),
    .dig_en   (dig_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with in_ready high: present v, let the next posedge accept it.
  task automatic start(input logic [15:0] v, input bit hold);
    in_valid = 1'b1;
    in_data  = v;
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!hold) begin
      in_valid = 1'b0;
      in_data  = 16'(($urandom));
    end
  endtask

  // Called just after the accepting edge. Returns at the negedge where done is seen.
  task automatic wait_done(input string tag, input logic [19:0] eb, input logic [4:0] ee);
    logic [19:0] pb;
    logic [4:0]  pe;
    int low, holdbad, cyc;
    bit seen;
    pb = bcd; pe = dig_en;
    low = 0; holdbad = 0; cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
      else begin
        if (!in_ready) low++;
        if (bcd !== pb || dig_en !== pe) holdbad++;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'd17);
    chk({tag, "_ready_low"}, 32'(low), 32'd16);
    chk({tag, "_hold"}, 32'(holdbad), 32'd0);
    chk({tag, "_ready_at_done"}, 32'(in_ready), 32'd1);
    chk({tag, "_bcd"}, 32'(bcd), 32'(eb));
    chk({tag, "_en"}, 32'(dig_en), 32'(ee));
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    blank    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_en", 32'(dig_en), 32'h01);
    rst_n = 1'b1;

    // No spurious done while idle
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("idle_no_done", 32'(n), 32'd0);
    chk("idle_bcd", 32'(bcd), 32'h0);

    // 12345, outputs held at reset values during conversion
    start(16'd12345, 1'b0);
    wait_done("v12345", 20'h12345, 5'b11111);
    @(negedge clk);
    chk("v12345_done_pulse", 32'(done), 32'd0);

    // 65535 then 7 back-to-back with in_valid held
    start(16'd65535, 1'b1);
    wait_done("v65535", 20'h65535, 5'b11111);
    in_data = 16'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done("v7", 20'h00007, 5'b00001);

    // 100 then 0
    @(negedge clk);
    start(16'd100, 1'b0);
    wait_done("v100", 20'h00100, 5'b00111);
    @(negedge clk);
    start(16'd0, 1'b0);
    wait_done("v0", 20'h00000, 5'b00001);

    // 4096 then blank toggling
    @(negedge clk);
    start(16'd4096, 1'b0);
    wait_done("v4096", 20'h04096, 5'b01111);
    @(negedge clk);
    blank = 1'b1;
    #1;
    chk("blank_en", 32'(dig_en), 32'h0);
    chk("blank_bcd", 32'(bcd), 32'h04096);
    blank = 1'b0;
    #1;
    chk("unblank_en", 32'(dig_en), 32'h0F);

    // 999 aborted by reset mid-conversion
    @(negedge clk);
    start(16'd999, 1'b0);
    repeat (8) @(negedge clk);
    chk("abort_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_bcd", 32'(bcd), 32'h0);
    chk("abort_en", 32'(dig_en), 32'h01);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) n++;
    end
    chk("abort_no_done", 32'(n), 32'd0);
    chk("abort_bcd_after", 32'(bcd), 32'h0);

    // Recovery with 42
    start(16'd42, 1'b0);
    wait_done("v42", 20'h00042, 5'b00011);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_disp_ctrl.md
# seg_disp_ctrl

Sequencing controller for a bank of `bcd7seg` decoders. It accepts a binary value over a valid/ready handshake and converts it to BCD with a sequential shift-add-3 (double-dabble) engine, one bit per cycle. It then drives the per-digit nibble and enable inputs of DIGITS `bcd7seg` instances, with leading-zero blanking and a global blank override. It sits between the CPU-side status/debug logic and the seven-segment decoders on the board top level.

## Interface
- WIDTH, 16, bit width of the binary input value.
- DIGITS, 5, number of BCD digits / `bcd7seg` instances driven. Must satisfy 10^DIGITS > 2^WIDTH − 1, so no overflow is possible.

- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset. Asserts immediately, releases synchronously to clk.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  WIDTH  unsigned binary value to display.
- in_ready  output  1  controller can accept a value. Equals (state == IDLE).
- blank  input  1  level; forces all digit enables low while high.
- done  output  1  one-cycle pulse: the display outputs have just been updated.
- bcd  output  4*DIGITS  digit nibbles. Digit i (i=0 least significant) occupies bits [4i+3:4i]. Feeds `bcd7seg.x`.
- dig_en  output  DIGITS  per-digit enable, bit i feeds `bcd7seg.en` of digit i.

## Operation
- States: IDLE, CONV.
- IDLE: in_ready=1. On in_valid && in_ready at a clock edge:
  - load shift register sh <= in_data;
  - clear accumulator acc (4*DIGITS bits) to 0;
  - set cnt <= WIDTH;
  - go to CONV.
  - in_valid without in_ready is ignored. No queuing is performed; the source must hold the value until the handshake completes.
- CONV: each cycle:
  - every acc nibble ≥ 5 gets +3, with no carry into the next nibble;
  - then {acc, sh} shifts left by 1;
  - cnt decrements.
  - On the cycle where cnt==1, the shift completes, the result is written to the display registers, and the state returns to IDLE.
- Display register update (same edge as the last shift):
  - bcd_reg <= final acc.
  - en_reg[0] <= 1 always, so a value of 0 shows "0".
  - en_reg[i], i≥1 <= 1 iff any nibble j≥i of the final acc is nonzero (leading-zero blanking).
  - done <= 1 for exactly one cycle.
- dig_en = en_reg & {DIGITS{~blank}}, combinational. blank does not affect bcd, state or done.
- bcd and dig_en hold their previous values throughout CONV and change only at the update edge.
- Width rules:
  - cnt is $clog2(WIDTH+1) bits.
  - Add-3 is applied only to nibbles before the shift.
  - The final acc nibbles are all ≤ 9.

## Timing
- Handshake accepted at edge E0. CONV occupies the WIDTH cycles after E0. Outputs update and done=1 in the cycle following edge E0+WIDTH.
- in_ready is low for exactly WIDTH cycles and is high again in the same cycle done is high. A new value may be accepted in that cycle, giving back-to-back throughput of one conversion per WIDTH+1 cycles.
- Latency from in_valid&in_ready to updated display: WIDTH cycles (16 by default).
- blank → dig_en: 0 cycles, combinational.
- Reset values, applied while rst_n=0:
  - state=IDLE, so in_ready=1;
  - done=0;
  - bcd=0;
  - en_reg = one-hot bit 0, so dig_en = 1 when blank=0;
  - sh, acc, cnt = 0.
- Reset during CONV aborts the conversion. The display returns to "0" and the aborted value is never shown; done does not pulse.
- in_data changes during CONV have no effect.

## Test plan
- Reset release with blank=0: bcd=0x00000, dig_en=5'b00001, in_ready=1, done=0. No done pulse for 50 cycles with in_valid=0.
- Send 12345 (0x3039): in_ready low 16 cycles, then done pulses once. bcd=0x12345, dig_en=5'b11111, and the outputs were unchanged (still the reset values) during CONV.
- Send 65535, then 7 back-to-back (in_valid held, second value accepted in the done cycle): first result bcd=0x65535, en=5'b11111. 17 cycles later bcd=0x00007, en=5'b00001.
- Send 100, then 0: bcd=0x00100, en=5'b00111. Then bcd=0x00000, en=5'b00001.
- Assert blank after displaying 4096: dig_en=0 in the same cycle and bcd remains 0x04096. Deassert: dig_en=5'b01111 immediately.
- Accept 999, pulse rst_n low for 1 cycle at CONV cycle 8: done never pulses, bcd=0, dig_en=5'b00001. The next accepted value (42) yields bcd=0x00042, en=5'b00011 after 16 cycles.
